// File: rtl/serial_parity_rx.sv
// Purpose: async single-wire frame receiver (start, DATA_BITS LSB-first, parity, stop) with parity/framing flags.
// Latency: data_valid at rx_s fall + CLKS_PER_BIT/2 + (DATA_BITS+2)*CLKS_PER_BIT + 1 (one bit less without parity).
// Backpressure: none; data_valid is a one-cycle strobe and the consumer must take data_out when it fires.
// Optional feature: define SERIAL_RX_PARITY_EN to carry and check the parity bit; undefined drops it and ties parity_err low.
`timescale 1ns/1ps

module serial_parity_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t state, state_nxt;

  logic                 rx_meta, rx_s, rx_prev;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  logic fall_edge, mid_hit, bit_hit, last_data;
  logic cnt_clr, bit_clr, start_ok, shift_en, frame_done;

  assign fall_edge = rx_prev & ~rx_s;
  assign mid_hit   = (cnt == HALF_LAST);
  assign bit_hit   = (cnt == BIT_LAST);
  assign last_data = (bit_cnt == DATA_LAST);

  // Two-flop synchronizer plus one delayed copy for the idle falling-edge detector; idle level is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: half-bit wait to reach the start-bit centre, then whole bits after that.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fall_edge) state_nxt = S_START;
      S_START: if (mid_hit)   state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef SERIAL_RX_PARITY_EN
      S_DATA:   if (bit_hit && last_data) state_nxt = S_PARITY;
      S_PARITY: if (bit_hit)              state_nxt = S_STOP;
`else
      S_DATA:   if (bit_hit && last_data) state_nxt = S_STOP;
`endif
      S_STOP:  if (bit_hit)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state control strobes: counter restart points and the sample enables for each bit type.
`ifdef SERIAL_RX_PARITY_EN
  logic par_en;
`endif
  always_comb begin
    cnt_clr    = 1'b0;
    bit_clr    = 1'b0;
    start_ok   = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = fall_edge;
      end
      S_START: if (mid_hit) begin
        cnt_clr  = 1'b1;
        start_ok = ~rx_s;
      end
      S_DATA: if (bit_hit) begin
        cnt_clr  = 1'b1;
        shift_en = 1'b1;
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: if (bit_hit) begin
        cnt_clr = 1'b1;
        par_en  = 1'b1;
      end
`endif
      S_STOP: if (bit_hit) begin
        cnt_clr    = 1'b1;
        frame_done = 1'b1;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Clock-per-bit counter; held at zero while idle so START always measures from the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  // Data bit counter and LSB-first shift register; every bit is overwritten each frame, so no clear is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (bit_clr || start_ok) bit_cnt <= '0;
      else if (shift_en)       bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_acc;

  // Running XOR over data bits and the received parity bit; the result is 0 for a good even-parity frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     par_acc <= 1'b0;
    else if (start_ok)           par_acc <= 1'b0;
    else if (shift_en || par_en) par_acc <= par_acc ^ rx_s;
  end

  // Parity flag updates only with a delivered frame and holds until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             parity_err <= 1'b0;
    else if (frame_done) parity_err <= par_acc ^ ODD;
  end
`else
  // No parity bit on the wire, so there is never a parity error to report.
  assign parity_err = 1'b0;
`endif

  // Frame delivery: word, framing flag, one-cycle strobe and the busy window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= frame_done;
      if (frame_done) begin
        data_out  <= shift_reg;
        frame_err <= ~rx_s;
      end
      if (start_ok)        busy <= 1'b1;
      else if (frame_done) busy <= 1'b0;
    end
  end

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial frame receiver that recovers a byte from an asynchronous single-wire line and checks the XOR parity bit appended by the transmit side. It is the receiving end of the team's parity-protected serial link. It sits between the external `rx_in` pin and the parallel datapath. Each completed frame produces one data word, a one-cycle valid strobe, and parity/framing error flags.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; must be even and ≥ 4.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.

- `clk`, input, 1: single system clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rx_in`, input, 1: serial line; idles high and is asynchronous to `clk`.
- `data_out`, output, DATA_BITS: last received word.
- `data_valid`, output, 1: one-cycle pulse when `data_out` and the flags update.
- `parity_err`, output, 1: parity mismatch on the last frame.
- `frame_err`, output, 1: stop bit sampled low on the last frame.
- `busy`, output, 1: high from a confirmed start bit through the end of the stop bit.

## Operation
- **Synchronizer:** `rx_in` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- **Frame format:** start bit (0), DATA_BITS data bits (LSB first), parity bit, stop bit (1).
- **IDLE state:**
  - A falling edge on `rx_s` (previous 1, current 0) moves the FSM to START and clears the bit counter.
  - A line held low does not retrigger; a new 1→0 edge is required.
- **START state:**
  - At count CLKS_PER_BIT/2−1, `rx_s` is sampled.
  - If `rx_s` = 0, the start is confirmed: `busy` goes to 1, the counter clears, and the FSM moves to DATA.
  - If `rx_s` = 1, the start is treated as a glitch: the FSM returns to IDLE and `busy` stays 0.
- **DATA state:**
  - `rx_s` is sampled every CLKS_PER_BIT cycles, i.e. at bit centres.
  - Each sample shifts into a shift register (LSB first) and XORs into the running parity.
  - After DATA_BITS samples, the FSM moves to PARITY.
- **PARITY state:** samples the parity bit, then moves to STOP.
  - With even parity, the error condition is running XOR of the data bits ^ parity bit ≠ 0.
  - With odd parity, the error condition is that the same XOR ≠ 1.
- **STOP state:** samples the stop bit; `frame_err` is set if it is 0. Then, on the next clock:
  - `data_out` loads the shift register.
  - `parity_err` and `frame_err` update.
  - `data_valid` pulses for exactly 1 cycle.
  - `busy` drops to 0 and the FSM returns to IDLE.
- **Errored frames:** data is still delivered; the flags report the errors. Flags hold their value until the next `data_valid`.
- **Reset behaviour:** `rst` at any time, including mid-frame, immediately gives:
  - FSM = IDLE, counters = 0;
  - `data_out` = 0, `data_valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0.
  - A partial frame is discarded with no `data_valid`.
- **Back-to-back frames:** a start edge that follows the stop sample with no idle gap is accepted. The IDLE edge detector sees the 1→0 transition because the stop bit was 1.

## Timing
- **`rx_in` to `rx_s`:** 2 cycles.
- **`data_valid` latency:** asserted at synchronized start edge + CLKS_PER_BIT/2 + (DATA_BITS+2)·CLKS_PER_BIT + 1 cycles. With defaults this is 169 cycles after the `rx_s` falling edge.
- **`busy`:** rises 1 cycle after the confirmed start sample. It falls in the same cycle `data_valid` is high.
- **`data_valid`:** never high for 2 consecutive cycles; the minimum spacing is one full frame.
- **Outputs:** all outputs are registered; there are no combinational paths from `rx_in`.

## Configuration
- **`SERIAL_RX_PARITY_EN` defined:** frames carry a parity bit and the PARITY state exists, as described above.
- **`SERIAL_RX_PARITY_EN` undefined:**
  - The PARITY state is removed and STOP follows the last data bit.
  - The frame is DATA_BITS+2 bits long and latency drops by CLKS_PER_BIT.
  - `parity_err` is tied to 0 and `PARITY_ODD` is ignored.

## Test plan
Bench settings: CLKS_PER_BIT=16, DATA_BITS=8, even parity, `SERIAL_RX_PARITY_EN` defined. Frames are driven at 16 clocks per bit.
- **Reset:** assert `rst` with `rx_in`=1 → `data_out`=0x00, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
- **Good frame:** send 0xA5 with parity 0 and stop 1 → `data_out`=0xA5, a single `data_valid` pulse, both flags 0, `busy` low afterward.
- **Bad parity:** send 0x3C with parity 1 → `data_out`=0x3C, `parity_err`=1, `frame_err`=0. A following good 0x55 frame clears `parity_err` to 0.
- **Bad stop bit:** send 0xFF with stop bit 0 → `frame_err`=1 and `data_out`=0xFF.
- **Glitch rejection:** drive `rx_in` low for 4 clocks, then high → `busy` stays 0 and there is no `data_valid`.
- **Reset mid-frame:** assert `rst` during the 4th data bit of 0x12 → outputs return to 0 immediately with no `data_valid`. A following 0x81 frame is received correctly.
